// File: rtl/inst_mem_pkg.sv
// Shared definitions for the instruction-memory blocks: the program-loader
// state encoding used by the write-port arbiter in front of inst_control.
package inst_mem_pkg;

   // Loader state: IDLE owns the port for the host, LOAD owns it for the
   // stream, DONE is a single announcement cycle before returning to IDLE.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      DONE = 2'd2
   } ld_state_e;

endpackage : inst_mem_pkg

// File: rtl/inst_mem_load_arbiter.sv
// Instruction-memory write-port arbiter. Host CSR writes get the port while
// the loader is idle; a streaming load (valid/ready) owns it while running.
// The write port is fully registered. When a load completes, the block can
// optionally pulse the core start.
module inst_mem_load_arbiter
   import inst_mem_pkg::*;
#(
   parameter  int RegAddrWidth     = 32,
   parameter  int InstMemDepth     = 128,
   localparam int InstMemAddrWidth = $clog2(InstMemDepth)
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    clr_i,

   input  logic                    host_wr_en_i,
   input  logic [RegAddrWidth-1:0] host_wr_addr_i,
   input  logic [RegAddrWidth-1:0] host_wr_data_i,
   output logic                    host_wr_ready_o,

   input  logic                    ld_start_i,
   input  logic [RegAddrWidth-1:0] ld_base_addr_i,
   input  logic [RegAddrWidth-1:0] ld_len_i,
   input  logic                    ld_auto_run_i,
   input  logic                    core_busy_i,

   input  logic                    s_valid_i,
   input  logic [RegAddrWidth-1:0] s_data_i,
   output logic                    s_ready_o,

   output logic                    inst_wr_en_o,
   output logic [RegAddrWidth-1:0] inst_wr_addr_o,
   output logic [RegAddrWidth-1:0] inst_wr_data_o,

   output logic                    core_start_o,
   output logic                    ld_busy_o,
   output logic                    ld_done_o,
   output logic                    ld_err_o
);

   // Keeps only the word-index bits of an address, i.e. the zero-extended
   // memory index. Masking instead of slicing keeps every input bit in use.
   localparam logic [RegAddrWidth-1:0] AddrMask =
      RegAddrWidth'((1 << InstMemAddrWidth) - 1);

   // Depth widened by one bit so base+len can be compared without wrapping.
   localparam logic [RegAddrWidth:0] DepthExt = (RegAddrWidth + 1)'(InstMemDepth);

   ld_state_e               r_state;
   logic [RegAddrWidth-1:0] r_base;
   logic [RegAddrWidth-1:0] r_len;
   logic [RegAddrWidth-1:0] r_count;
   logic                    r_autoRun;

   logic                    r_wrEn;
   logic [RegAddrWidth-1:0] r_wrAddr;
   logic [RegAddrWidth-1:0] r_wrData;
   logic                    r_coreStart;
   logic                    r_busy;
   logic                    r_done;
   logic                    r_err;

   logic [RegAddrWidth:0]   w_loadEnd;
   logic                    w_outOfRange;
   logic                    w_lenZero;
   logic                    w_lastBeat;
   logic                    w_beatTaken;
   logic [RegAddrWidth-1:0] w_beatAddr;
   logic [RegAddrWidth-1:0] w_hostAddr;

   // Load range check, computed one bit wider so that a huge base or length
   // can never wrap around and pass.
   assign w_loadEnd    = {1'b0, ld_base_addr_i} + {1'b0, ld_len_i};
   assign w_outOfRange = (w_loadEnd > DepthExt);
   assign w_lenZero    = (ld_len_i == '0);

   // Stream bookkeeping. A beat counts only when the stream is actually
   // ready, which also excludes the clear cycle.
   assign w_lastBeat  = (r_count == (r_len - RegAddrWidth'(1)));
   assign w_beatTaken = s_valid_i && s_ready_o;
   assign w_beatAddr  = (r_base + r_count) & AddrMask;
   assign w_hostAddr  = host_wr_addr_i & AddrMask;

   // Ready signals follow the state only, so neither side can see a
   // combinational path from its own request to its ready. A clear takes
   // stream ready down in the same cycle, so no beat slips in while aborting.
   assign host_wr_ready_o = (r_state == IDLE);
   assign s_ready_o       = (r_state == LOAD) && !clr_i;

   assign inst_wr_en_o   = r_wrEn;
   assign inst_wr_addr_o = r_wrAddr;
   assign inst_wr_data_o = r_wrData;
   assign core_start_o   = r_coreStart;
   assign ld_busy_o      = r_busy;
   assign ld_done_o      = r_done;
   assign ld_err_o       = r_err;

   // Loader FSM with its counters and the registered write port / status
   // outputs, all updated together so each pulse lines up with its state.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state     <= IDLE;
         r_base      <= '0;
         r_len       <= '0;
         r_count     <= '0;
         r_autoRun   <= 1'b0;
         r_wrEn      <= 1'b0;
         r_wrAddr    <= '0;
         r_wrData    <= '0;
         r_coreStart <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else if (clr_i) begin
         r_state     <= IDLE;
         r_base      <= '0;
         r_len       <= '0;
         r_count     <= '0;
         r_autoRun   <= 1'b0;
         r_wrEn      <= 1'b0;
         r_wrAddr    <= '0;
         r_wrData    <= '0;
         r_coreStart <= 1'b0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         r_wrEn      <= 1'b0;
         r_coreStart <= 1'b0;
         r_done      <= 1'b0;

         case (r_state)
            IDLE: begin
               if (host_wr_en_i) begin
                  r_wrEn   <= 1'b1;
                  r_wrAddr <= w_hostAddr;
                  r_wrData <= host_wr_data_i;
               end
               if (ld_start_i) begin
                  if (core_busy_i || w_outOfRange) begin
                     r_err <= 1'b1;
                  end else begin
                     r_base    <= ld_base_addr_i;
                     r_len     <= ld_len_i;
                     r_autoRun <= ld_auto_run_i;
                     r_count   <= '0;
                     r_err     <= 1'b0;
                     if (w_lenZero) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_coreStart <= ld_auto_run_i;
                     end else begin
                        r_state <= LOAD;
                        r_busy  <= 1'b1;
                     end
                  end
               end
            end

            LOAD: begin
               if (w_beatTaken) begin
                  r_wrEn   <= 1'b1;
                  r_wrAddr <= w_beatAddr;
                  r_wrData <= s_data_i;
                  r_count  <= r_count + RegAddrWidth'(1);
                  if (w_lastBeat) begin
                     r_state     <= DONE;
                     r_busy      <= 1'b0;
                     r_done      <= 1'b1;
                     r_coreStart <= r_autoRun;
                  end
               end
            end

            DONE: begin
               r_state <= IDLE;
            end

            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule : inst_mem_load_arbiter

// File: tb/tb_inst_mem_load_arbiter.sv
// Directed, table-driven bench for inst_mem_load_arbiter. Each table row
// holds the inputs for one cycle and the outputs expected just after the
// following rising edge. The multi-cycle clear and async-reset cases are
// written out by hand afterwards.
module tb_inst_mem_load_arbiter;

   typedef struct packed {
      logic        hostEn;
      logic [31:0] hostAddr;
      logic [31:0] hostData;
      logic        ldStart;
      logic [31:0] base;
      logic [31:0] len;
      logic        autoRun;
      logic        coreBusy;
      logic        sValid;
      logic [31:0] sData;
   } in_t;

   typedef struct packed {
      logic        hostRdy;
      logic        sRdy;
      logic        wrEn;
      logic [31:0] wrAddr;
      logic [31:0] wrData;
      logic        coreStart;
      logic        busy;
      logic        done;
      logic        err;
   } out_t;

   typedef struct packed {
      in_t  stim;
      out_t exp;
   } vec_t;

   localparam int NumVecs = 25;

   logic        clk;
   logic        rst;
   logic        clr;
   logic        hostWrEn;
   logic [31:0] hostWrAddr;
   logic [31:0] hostWrData;
   logic        hostWrReady;
   logic        ldStart;
   logic [31:0] ldBase;
   logic [31:0] ldLen;
   logic        ldAutoRun;
   logic        coreBusy;
   logic        sValid;
   logic [31:0] sData;
   logic        sReady;
   logic        instWrEn;
   logic [31:0] instWrAddr;
   logic [31:0] instWrData;
   logic        coreStart;
   logic        ldBusy;
   logic        ldDone;
   logic        ldErr;

   int   checks;
   int   errors;
   vec_t vecs [NumVecs];

   inst_mem_load_arbiter #(
      .RegAddrWidth (32),
      .InstMemDepth (128)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .clr_i           (clr),
      .host_wr_en_i    (hostWrEn),
      .host_wr_addr_i  (hostWrAddr),
      .host_wr_data_i  (hostWrData),
      .host_wr_ready_o (hostWrReady),
      .ld_start_i      (ldStart),
      .ld_base_addr_i  (ldBase),
      .ld_len_i        (ldLen),
      .ld_auto_run_i   (ldAutoRun),
      .core_busy_i     (coreBusy),
      .s_valid_i       (sValid),
      .s_data_i        (sData),
      .s_ready_o       (sReady),
      .inst_wr_en_o    (instWrEn),
      .inst_wr_addr_o  (instWrAddr),
      .inst_wr_data_o  (instWrData),
      .core_start_o    (coreStart),
      .ld_busy_o       (ldBusy),
      .ld_done_o       (ldDone),
      .ld_err_o        (ldErr)
   );

   // Free-running 100 MHz clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Helpers for building table rows compactly
   function automatic in_t idleIn();
      in_t s;
      s = '0;
      return s;
   endfunction

   function automatic in_t hostIn(input logic [31:0] a, input logic [31:0] d);
      in_t s;
      s = '0;
      s.hostEn   = 1'b1;
      s.hostAddr = a;
      s.hostData = d;
      return s;
   endfunction

   function automatic in_t startIn(input logic [31:0] b, input logic [31:0] l,
                                   input logic ar, input logic bsy);
      in_t s;
      s = '0;
      s.ldStart  = 1'b1;
      s.base     = b;
      s.len      = l;
      s.autoRun  = ar;
      s.coreBusy = bsy;
      return s;
   endfunction

   function automatic in_t beatIn(input logic [31:0] d);
      in_t s;
      s = '0;
      s.sValid = 1'b1;
      s.sData  = d;
      return s;
   endfunction

   function automatic out_t mkOut(input logic hr, input logic sr, input logic we,
                                  input logic [31:0] a, input logic [31:0] d,
                                  input logic cs, input logic bz, input logic dn,
                                  input logic er);
      out_t o;
      o.hostRdy   = hr;
      o.sRdy      = sr;
      o.wrEn      = we;
      o.wrAddr    = a;
      o.wrData    = d;
      o.coreStart = cs;
      o.busy      = bz;
      o.done      = dn;
      o.err       = er;
      return o;
   endfunction

   function automatic out_t sampleDut();
      return mkOut(hostWrReady, sReady, instWrEn, instWrAddr, instWrData,
                   coreStart, ldBusy, ldDone, ldErr);
   endfunction

   task automatic applyStimulus(input in_t s);
      hostWrEn   = s.hostEn;
      hostWrAddr = s.hostAddr;
      hostWrData = s.hostData;
      ldStart    = s.ldStart;
      ldBase     = s.base;
      ldLen      = s.len;
      ldAutoRun  = s.autoRun;
      coreBusy   = s.coreBusy;
      sValid     = s.sValid;
      sData      = s.sData;
   endtask

   task automatic checkOutput(input string name, input out_t exp);
      out_t act;
      act = sampleDut();
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got rdyH=%b rdyS=%b we=%b a=%h d=%h cs=%b bz=%b dn=%b er=%b, want rdyH=%b rdyS=%b we=%b a=%h d=%h cs=%b bz=%b dn=%b er=%b",
                  name, act.hostRdy, act.sRdy, act.wrEn, act.wrAddr, act.wrData,
                  act.coreStart, act.busy, act.done, act.err,
                  exp.hostRdy, exp.sRdy, exp.wrEn, exp.wrAddr, exp.wrData,
                  exp.coreStart, exp.busy, exp.done, exp.err);
      end
   endtask

   task automatic checkBit(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %b, want %b", name, act, exp);
      end
   endtask

   task automatic stepCycle(input in_t s);
      applyStimulus(s);
      @(posedge clk);
      #1;
   endtask

   // Main test sequence
   initial begin
      checks   = 0;
      errors   = 0;
      rst      = 1'b1;
      clr      = 1'b0;
      applyStimulus(idleIn());

      //                 inputs                                       hR sR we addr          data          cs bz dn er
      vecs[0]  = '{hostIn(32'h10, 32'hA5A5_A5A5),      mkOut(1, 0, 1, 32'h10, 32'hA5A5_A5A5, 0, 0, 0, 0)};
      vecs[1]  = '{idleIn(),                           mkOut(1, 0, 0, 32'h10, 32'hA5A5_A5A5, 0, 0, 0, 0)};
      vecs[2]  = '{startIn(32'd4, 32'd3, 1'b1, 1'b0),  mkOut(0, 1, 0, 32'h10, 32'hA5A5_A5A5, 0, 1, 0, 0)};
      vecs[3]  = '{beatIn(32'h1111_1111),              mkOut(0, 1, 1, 32'd4,  32'h1111_1111, 0, 1, 0, 0)};
      vecs[4]  = '{idleIn(),                           mkOut(0, 1, 0, 32'd4,  32'h1111_1111, 0, 1, 0, 0)};
      vecs[5]  = '{beatIn(32'h2222_2222),              mkOut(0, 1, 1, 32'd5,  32'h2222_2222, 0, 1, 0, 0)};
      vecs[5].stim.hostEn   = 1'b1;
      vecs[5].stim.hostAddr = 32'h20;
      vecs[5].stim.hostData = 32'hBEEF;
      vecs[6]  = '{hostIn(32'h20, 32'hBEEF),           mkOut(0, 1, 0, 32'd5,  32'h2222_2222, 0, 1, 0, 0)};
      vecs[7]  = '{beatIn(32'h3333_3333),              mkOut(0, 0, 1, 32'd6,  32'h3333_3333, 1, 0, 1, 0)};
      vecs[7].stim.hostEn   = 1'b1;
      vecs[7].stim.hostAddr = 32'h20;
      vecs[7].stim.hostData = 32'hBEEF;
      vecs[8]  = '{hostIn(32'h20, 32'hBEEF),           mkOut(1, 0, 0, 32'd6,  32'h3333_3333, 0, 0, 0, 0)};
      vecs[9]  = '{hostIn(32'h20, 32'hBEEF),           mkOut(1, 0, 1, 32'h20, 32'h0000_BEEF, 0, 0, 0, 0)};
      vecs[10] = '{startIn(32'd8, 32'd0, 1'b0, 1'b0),  mkOut(0, 0, 0, 32'h20, 32'h0000_BEEF, 0, 0, 1, 0)};
      vecs[11] = '{beatIn(32'hDEAD_0000),              mkOut(1, 0, 0, 32'h20, 32'h0000_BEEF, 0, 0, 0, 0)};
      vecs[12] = '{startIn(32'd0, 32'd1, 1'b0, 1'b1),  mkOut(1, 0, 0, 32'h20, 32'h0000_BEEF, 0, 0, 0, 1)};
      vecs[13] = '{startIn(32'd0, 32'd1, 1'b0, 1'b0),  mkOut(0, 1, 0, 32'h20, 32'h0000_BEEF, 0, 1, 0, 0)};
      vecs[14] = '{beatIn(32'h4444_4444),              mkOut(0, 0, 1, 32'd0,  32'h4444_4444, 0, 0, 1, 0)};
      vecs[15] = '{idleIn(),                           mkOut(1, 0, 0, 32'd0,  32'h4444_4444, 0, 0, 0, 0)};
      vecs[16] = '{startIn(32'd126, 32'd3, 1'b0, 1'b0),mkOut(1, 0, 0, 32'd0,  32'h4444_4444, 0, 0, 0, 1)};
      vecs[17] = '{startIn(32'd126, 32'd2, 1'b0, 1'b0),mkOut(0, 1, 0, 32'd0,  32'h4444_4444, 0, 1, 0, 0)};
      vecs[18] = '{beatIn(32'h5555_5555),              mkOut(0, 1, 1, 32'd126,32'h5555_5555, 0, 1, 0, 0)};
      vecs[19] = '{beatIn(32'h6666_6666),              mkOut(0, 0, 1, 32'd127,32'h6666_6666, 0, 0, 1, 0)};
      vecs[20] = '{idleIn(),                           mkOut(1, 0, 0, 32'd127,32'h6666_6666, 0, 0, 0, 0)};
      vecs[21] = '{startIn(32'd10, 32'd1, 1'b1, 1'b0), mkOut(0, 1, 1, 32'h30, 32'h77,        0, 1, 0, 0)};
      vecs[21].stim.hostEn   = 1'b1;
      vecs[21].stim.hostAddr = 32'h30;
      vecs[21].stim.hostData = 32'h77;
      vecs[22] = '{beatIn(32'h88),                     mkOut(0, 0, 1, 32'd10, 32'h88,        1, 0, 1, 0)};
      vecs[23] = '{idleIn(),                           mkOut(1, 0, 0, 32'd10, 32'h88,        0, 0, 0, 0)};
      vecs[24] = '{startIn(32'hFFFF_FFFF, 32'd2, 1'b0, 1'b0),
                                                       mkOut(1, 0, 0, 32'd10, 32'h88,        0, 0, 0, 1)};

      // Reset values while reset is held
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_held", mkOut(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      checkOutput("after_reset", mkOut(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0));

      // Table-driven part
      for (int i = 0; i < NumVecs; i++) begin
         stepCycle(vecs[i].stim);
         checkOutput($sformatf("vec%0d", i), vecs[i].exp);
      end

      // Clear after 2 of 5 beats: abort, no pulses, stream ready drops at once
      stepCycle(startIn(32'd40, 32'd5, 1'b1, 1'b0));
      checkOutput("clr_start", mkOut(0, 1, 0, 32'd10, 32'h88, 0, 1, 0, 0));
      stepCycle(beatIn(32'hC0));
      checkOutput("clr_beat0", mkOut(0, 1, 1, 32'd40, 32'hC0, 0, 1, 0, 0));
      stepCycle(beatIn(32'hC1));
      checkOutput("clr_beat1", mkOut(0, 1, 1, 32'd41, 32'hC1, 0, 1, 0, 0));
      applyStimulus(beatIn(32'hC2));
      clr = 1'b1;
      #1;
      checkBit("clr_sready_same_cycle", sReady, 1'b0);
      @(posedge clk);
      #1;
      checkOutput("clr_abort", mkOut(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0));
      clr = 1'b0;
      for (int i = 0; i < 3; i++) begin
         stepCycle(beatIn(32'hC3));
         checkOutput($sformatf("clr_quiet%0d", i), mkOut(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0));
      end

      // Asynchronous reset in the middle of a load
      stepCycle(startIn(32'd0, 32'd5, 1'b0, 1'b0));
      checkOutput("rst_start", mkOut(0, 1, 0, 32'h0, 32'h0, 0, 1, 0, 0));
      stepCycle(beatIn(32'h99));
      checkOutput("rst_beat0", mkOut(0, 1, 1, 32'h0, 32'h99, 0, 1, 0, 0));
      applyStimulus(idleIn());
      #2;
      rst = 1'b1;
      #1;
      checkOutput("rst_async", mkOut(1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0));
      @(negedge clk);
      rst = 1'b0;
      stepCycle(hostIn(32'h7F, 32'h1234));
      checkOutput("rst_recover", mkOut(1, 0, 1, 32'h7F, 32'h1234, 0, 0, 0, 0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_inst_mem_load_arbiter
